// File: rtl/bus_arbiter2_pkg.sv
// rtl/bus_arbiter2_pkg.sv - shared state encoding, select codes and bus width
package bus_arbiter2_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/multiplexer16bit.sv
// rtl/multiplexer16bit.sv - 2:1 word multiplexer, sel=0 passes A, sel=1 passes B
module multiplexer16bit
  import bus_arbiter2_pkg::*;
(
  input  logic [BUS_W-1:0] A,
  input  logic [BUS_W-1:0] B,
  input  logic             sel,
  output logic [BUS_W-1:0] Q
);

  assign Q = (sel == SEL_B) ? B : A;

endmodule

// File: rtl/bus_arbiter2.sv
// rtl/bus_arbiter2.sv - two-requester round-robin bus arbiter with capped locked bursts
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             lock_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic             lock_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             bus_sel,
  output logic [WIDTH-1:0] bus_q,
  output logic             bus_valid,
  input  logic             bus_ready
);

  state_t     r_state;
  logic       r_bus_sel;
  logic [3:0] r_burst_cnt;
  logic       r_last_b;

  logic       w_xfer;
  logic [3:0] w_cnt_inc;
  logic       w_burst_ok;

  assign gnt_a     = (r_state == ST_OWN_A);
  assign gnt_b     = (r_state == ST_OWN_B);
  assign bus_sel   = r_bus_sel;
  assign bus_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign w_xfer    = bus_valid & bus_ready;
  assign ack_a     = w_xfer & gnt_a;
  assign ack_b     = w_xfer & gnt_b;

  assign w_cnt_inc  = (r_burst_cnt == 4'hF) ? 4'hF : r_burst_cnt + 4'd1;
  // True when the owner may take one more locked transfer without exceeding the cap.
  assign w_burst_ok = (({1'b0, r_burst_cnt} + 5'd1) < 5'(MAX_BURST));

  multiplexer16bit u_mux (
    .A   (data_a),
    .B   (data_b),
    .sel (r_bus_sel),
    .Q   (bus_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bus_sel   <= SEL_A;
      r_burst_cnt <= 4'd0;
      r_last_b    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_burst_cnt <= 4'd0;
          if (req_a && (!req_b || r_last_b)) begin
            r_state   <= ST_OWN_A;
            r_bus_sel <= SEL_A;
          end else if (req_b) begin
            r_state   <= ST_OWN_B;
            r_bus_sel <= SEL_B;
          end
        end
        ST_OWN_A: begin
          if (w_xfer) begin
            r_last_b <= 1'b0;
            if (lock_a && w_burst_ok) begin
              r_burst_cnt <= w_cnt_inc;
            end else begin
              r_burst_cnt <= 4'd0;
              if (req_b) begin
                r_state   <= ST_OWN_B;
                r_bus_sel <= SEL_B;
              end else if (!req_a) begin
                r_state <= ST_IDLE;
              end
            end
          end else if (!req_a) begin
            r_burst_cnt <= 4'd0;
            if (req_b) begin
              r_state   <= ST_OWN_B;
              r_bus_sel <= SEL_B;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_OWN_B: begin
          if (w_xfer) begin
            r_last_b <= 1'b1;
            if (lock_b && w_burst_ok) begin
              r_burst_cnt <= w_cnt_inc;
            end else begin
              r_burst_cnt <= 4'd0;
              if (req_a) begin
                r_state   <= ST_OWN_A;
                r_bus_sel <= SEL_A;
              end else if (!req_b) begin
                r_state <= ST_IDLE;
              end
            end
          end else if (!req_b) begin
            r_burst_cnt <= 4'd0;
            if (req_a) begin
              r_state   <= ST_OWN_A;
              r_bus_sel <= SEL_A;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_burst_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule
